// File: rtl/dff_pipe_delay.sv
// rtl/dff_pipe_delay.sv - stallable WIDTH x DEPTH delay line with per-stage valid, tap and occupancy
module dff_pipe_delay #(
   parameter int                WIDTH     = 8,
   parameter int                DEPTH     = 4,
   parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}},
   localparam int               TW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int               CW        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             sclr,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic [TW-1:0]    tap_sel,
   output logic [WIDTH-1:0] tap_q,
   output logic             tap_valid,
   output logic [CW-1:0]    fill_cnt
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;
   logic [CW-1:0]    fill_q;
   logic [CW-1:0]    fill_d;

   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      fill_d = fill_q;
      if (sclr) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = RESET_VAL;
         end
         vld_d  = '0;
         fill_d = '0;
      end else if (en) begin
         data_d[0] = d;
         vld_d[0]  = d_valid;
         for (int i = 1; i < DEPTH; i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
         // Entry and exit cancel; the count tracks popcount(vld) without an adder tree.
         fill_d = fill_q + CW'(d_valid) - CW'(vld_q[DEPTH-1]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= RESET_VAL;
         end
         vld_q  <= '0;
         fill_q <= '0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
         fill_q <= fill_d;
      end
   end

   // Out-of-range selects fall through to the reset value instead of indexing past the array.
   always_comb begin
      tap_q     = RESET_VAL;
      tap_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (tap_sel == TW'(i)) begin
            tap_q     = data_q[i];
            tap_valid = vld_q[i];
         end
      end
   end

   assign q        = data_q[DEPTH-1];
   assign q_valid  = vld_q[DEPTH-1];
   assign fill_cnt = fill_q;

endmodule
